// File: rtl/spi_cmd_scheduler_if.sv
// Packet-in / config-out / draw-command handshake bundle for spi_cmd_scheduler.
// The master side is the SPI accumulator and render engine; the slave side is the scheduler.
interface spi_cmd_scheduler_if;
  logic        i_Acc_DV;
  logic [63:0] i_Acc_Bytes;
  logic        o_Cfg_WE;
  logic [3:0]  o_Cfg_Addr;
  logic [31:0] o_Cfg_Data;
  logic        o_Cmd_Valid;
  logic [47:0] o_Cmd_Data;
  logic        i_Cmd_Ready;
  logic        i_Engine_Busy;
  logic [4:0]  o_Fifo_Level;
  logic        o_Overflow;
  logic [7:0]  o_Err_Count;

  modport master (
    output i_Acc_DV, i_Acc_Bytes, i_Cmd_Ready, i_Engine_Busy,
    input  o_Cfg_WE, o_Cfg_Addr, o_Cfg_Data, o_Cmd_Valid, o_Cmd_Data,
           o_Fifo_Level, o_Overflow, o_Err_Count
  );

  modport slave (
    input  i_Acc_DV, i_Acc_Bytes, i_Cmd_Ready, i_Engine_Busy,
    output o_Cfg_WE, o_Cfg_Addr, o_Cfg_Data, o_Cmd_Valid, o_Cmd_Data,
           o_Fifo_Level, o_Overflow, o_Err_Count
  );
endinterface

// File: rtl/spi_cmd_scheduler.sv
// Queues SPI packets and dispatches them as config writes, draw commands or engine syncs.
// state     | meaning
// IDLE      | waiting for a queued packet; pops the head when one exists
// DECODE    | acting on the popped packet's opcode
// ISSUE     | draw command presented, waiting for i_Cmd_Ready
// WAIT_IDLE | sync barrier, waiting for i_Engine_Busy to fall
module spi_cmd_scheduler #(
  parameter int N_BYTES    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst_,
  spi_cmd_scheduler_if.slave bus
);
  localparam int PW = N_BYTES * 8;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_DRAW  = 8'h02;
  localparam logic [7:0] OP_SYNC  = 8'h03;

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, WAIT_IDLE} state_t;

  state_t          state;
  logic [PW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [4:0]      count;
  logic [PW-1:0]   cmd_q;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic            unused_addr_hi;

  assign full = (count == 5'(FIFO_DEPTH));
  assign pop  = (state == IDLE) && (count != 5'd0);
  // A full queue still accepts a packet when the head leaves in the same cycle.
  assign push = bus.i_Acc_DV && (!full || pop);
  assign drop = bus.i_Acc_DV && full && !pop;
  assign bus.o_Fifo_Level = count;

  // Only the low nibble of the address byte selects a config register.
  assign unused_addr_hi = ^cmd_q[55:52];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.i_Acc_Bytes;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= 5'd0;
      cmd_q           <= '0;
      bus.o_Cfg_WE    <= 1'b0;
      bus.o_Cfg_Addr  <= 4'd0;
      bus.o_Cfg_Data  <= 32'd0;
      bus.o_Cmd_Valid <= 1'b0;
      bus.o_Cmd_Data  <= 48'd0;
      bus.o_Overflow  <= 1'b0;
      bus.o_Err_Count <= 8'd0;
    end else begin
      bus.o_Cfg_WE <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (drop) bus.o_Overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            cmd_q <= mem[rd_ptr];
            state <= DECODE;
          end
        end
        DECODE: begin
          case (cmd_q[63:56])
            OP_NOP: state <= IDLE;
            OP_WRITE: begin
              bus.o_Cfg_WE   <= 1'b1;
              bus.o_Cfg_Addr <= cmd_q[51:48];
              bus.o_Cfg_Data <= cmd_q[31:0];
              state          <= IDLE;
            end
            OP_DRAW: begin
              bus.o_Cmd_Valid <= 1'b1;
              bus.o_Cmd_Data  <= cmd_q[47:0];
              state           <= ISSUE;
            end
            OP_SYNC: state <= WAIT_IDLE;
            default: begin
              if (bus.o_Err_Count != 8'hFF) bus.o_Err_Count <= bus.o_Err_Count + 8'd1;
              state <= IDLE;
            end
          endcase
        end
        ISSUE: begin
          if (bus.i_Cmd_Ready) begin
            bus.o_Cmd_Valid <= 1'b0;
            state           <= IDLE;
          end
        end
        WAIT_IDLE: begin
          if (!bus.i_Engine_Busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler: a queue-level reference model compared every cycle,
// plus hand-computed cycle-exact expectations for each scenario.
module tb_spi_cmd_scheduler;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_;
  spi_cmd_scheduler_if bus();

  spi_cmd_scheduler #(.N_BYTES(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a packet queue plus the one packet currently being handled.
  logic [63:0] q[$];
  logic [63:0] cur;
  bit          have_cur, issuing, syncing;
  bit          m_we, m_valid, m_ovf;
  logic [3:0]  m_addr;
  logic [31:0] m_cdata;
  logic [47:0] m_cmd;
  logic [7:0]  m_err;

  task automatic model_step();
    bit take;
    logic [63:0] head;
    if (!rst_) begin
      q.delete();
      have_cur = 0; issuing = 0; syncing = 0;
      m_we = 0; m_valid = 0; m_ovf = 0;
      m_addr = '0; m_cdata = '0; m_cmd = '0; m_err = '0;
      return;
    end
    take = !have_cur && !issuing && !syncing && (q.size() > 0);
    m_we = 0;
    if (have_cur) begin
      have_cur = 0;
      case (cur[63:56])
        8'h00: ;
        8'h01: begin m_we = 1; m_addr = cur[51:48]; m_cdata = cur[31:0]; end
        8'h02: begin issuing = 1; m_valid = 1; m_cmd = cur[47:0]; end
        8'h03: syncing = 1;
        default: if (m_err != 8'hFF) m_err = m_err + 8'd1;
      endcase
    end else if (issuing && bus.i_Cmd_Ready) begin
      issuing = 0;
      m_valid = 0;
    end else if (syncing && !bus.i_Engine_Busy) begin
      syncing = 0;
    end
    if (take) begin
      head = q.pop_front();
      cur = head;
      have_cur = 1;
    end
    if (bus.i_Acc_DV) begin
      if (q.size() < DEPTH) q.push_back(bus.i_Acc_Bytes);
      else m_ovf = 1;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_cfg_we",    64'(bus.o_Cfg_WE),     64'(m_we));
      chk("m_cmd_valid", 64'(bus.o_Cmd_Valid),  64'(m_valid));
      chk("m_level",     64'(bus.o_Fifo_Level), 64'(q.size()));
      chk("m_overflow",  64'(bus.o_Overflow),   64'(m_ovf));
      chk("m_err_count", 64'(bus.o_Err_Count),  64'(m_err));
      if (m_we) begin
        chk("m_cfg_addr", 64'(bus.o_Cfg_Addr), 64'(m_addr));
        chk("m_cfg_data", 64'(bus.o_Cfg_Data), 64'(m_cdata));
      end
      if (m_valid) chk("m_cmd_data", 64'(bus.o_Cmd_Data), 64'(m_cmd));
    end
  end

  // Called at a falling edge; leaves the strobe low at the next falling edge.
  task automatic send(input logic [63:0] pkt);
    bus.i_Acc_DV    = 1'b1;
    bus.i_Acc_Bytes = pkt;
    @(negedge clk);
    bus.i_Acc_DV    = 1'b0;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  int hs;

  initial begin
    rst_ = 1'b0;
    bus.i_Acc_DV = 1'b0;
    bus.i_Acc_Bytes = '0;
    bus.i_Cmd_Ready = 1'b0;
    bus.i_Engine_Busy = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("rst_cfg_we",    64'(bus.o_Cfg_WE),     64'd0);
    chk("rst_cmd_valid", 64'(bus.o_Cmd_Valid),  64'd0);
    chk("rst_level",     64'(bus.o_Fifo_Level), 64'd0);
    chk("rst_overflow",  64'(bus.o_Overflow),   64'd0);
    chk("rst_err",       64'(bus.o_Err_Count),  64'd0);
    chk("rst_cfg_addr",  64'(bus.o_Cfg_Addr),   64'd0);
    chk("rst_cfg_data",  64'(bus.o_Cfg_Data),   64'd0);
    chk("rst_cmd_data",  64'(bus.o_Cmd_Data),   64'd0);
    rst_ = 1'b1;
    @(negedge clk);

    // WRITE_REG: strobe in cycle 3 only
    send(64'h01_05_0000DEADBEEF);
    chk("wr_c1_we", 64'(bus.o_Cfg_WE), 64'd0);
    @(negedge clk);
    chk("wr_c2_we", 64'(bus.o_Cfg_WE), 64'd0);
    @(negedge clk);
    chk("wr_c3_we",   64'(bus.o_Cfg_WE),   64'd1);
    chk("wr_c3_addr", 64'(bus.o_Cfg_Addr), 64'h5);
    chk("wr_c3_data", 64'(bus.o_Cfg_Data), 64'hDEADBEEF);
    @(negedge clk);
    chk("wr_c4_we", 64'(bus.o_Cfg_WE), 64'd0);
    repeat (2) @(negedge clk);

    // DRAW held off by ready for 5 cycles
    bus.i_Cmd_Ready = 1'b0;
    send(64'h02_00_123456789ABC);
    chk("draw_c1_valid", 64'(bus.o_Cmd_Valid), 64'd0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("draw_hold_valid", 64'(bus.o_Cmd_Valid), 64'd1);
      chk("draw_hold_data",  64'(bus.o_Cmd_Data),  64'h123456789ABC);
      @(negedge clk);
    end
    chk("draw_hs_valid", 64'(bus.o_Cmd_Valid), 64'd1);
    chk("draw_hs_data",  64'(bus.o_Cmd_Data),  64'h123456789ABC);
    bus.i_Cmd_Ready = 1'b1;
    @(negedge clk);
    chk("draw_after_valid", 64'(bus.o_Cmd_Valid), 64'd0);
    bus.i_Cmd_Ready = 1'b0;
    repeat (2) @(negedge clk);

    // SYNC blocks a queued WRITE_REG until the engine goes idle
    bus.i_Engine_Busy = 1'b1;
    send(64'h03_00_000000000000);
    send(64'h01_0A_000012345678);
    for (int k = 0; k < 10; k++) begin
      chk("sync_busy_we", 64'(bus.o_Cfg_WE), 64'd0);
      @(negedge clk);
    end
    bus.i_Engine_Busy = 1'b0;
    @(negedge clk);
    chk("sync_rel1_we", 64'(bus.o_Cfg_WE), 64'd0);
    @(negedge clk);
    chk("sync_rel2_we", 64'(bus.o_Cfg_WE), 64'd0);
    @(negedge clk);
    chk("sync_wr_we",   64'(bus.o_Cfg_WE),   64'd1);
    chk("sync_wr_addr", 64'(bus.o_Cfg_Addr), 64'hA);
    chk("sync_wr_data", 64'(bus.o_Cfg_Data), 64'h12345678);
    repeat (2) @(negedge clk);

    // Six back-to-back DRAWs into a depth-4 queue with the engine stalled
    bus.i_Cmd_Ready = 1'b0;
    for (int i = 0; i < 6; i++) send({8'h02, 8'h00, 48'(i + 1)});
    chk("ovf_level", 64'(bus.o_Fifo_Level), 64'd4);
    chk("ovf_flag",  64'(bus.o_Overflow),   64'd1);
    bus.i_Cmd_Ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.o_Cmd_Valid && bus.i_Cmd_Ready) hs++;
      @(negedge clk);
    end
    chk("ovf_issued", 64'(hs), 64'd5);
    chk("ovf_sticky", 64'(bus.o_Overflow), 64'd1);
    bus.i_Cmd_Ready = 1'b0;

    // Illegal opcodes saturate the error counter
    do_reset();
    for (int i = 0; i < 254; i++) begin
      send(64'h7F_00_000000000000);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("err_254", 64'(bus.o_Err_Count), 64'hFE);
    for (int i = 0; i < 46; i++) begin
      send(64'h7F_00_000000000000);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("err_sat",    64'(bus.o_Err_Count), 64'hFF);
    chk("err_no_ovf", 64'(bus.o_Overflow),  64'd0);
    for (int i = 0; i < 3; i++) send(64'h00_03_0000CAFEF00D);
    for (int k = 0; k < 10; k++) begin
      chk("nop_we",    64'(bus.o_Cfg_WE),    64'd0);
      chk("nop_valid", 64'(bus.o_Cmd_Valid), 64'd0);
      @(negedge clk);
    end
    chk("nop_err", 64'(bus.o_Err_Count), 64'hFF);

    // Reset while a DRAW is issuing with two more queued
    bus.i_Cmd_Ready = 1'b0;
    for (int i = 0; i < 3; i++) send({8'h02, 8'h00, 48'(16'hA0 + i)});
    chk("rsti_valid_pre", 64'(bus.o_Cmd_Valid),  64'd1);
    chk("rsti_level_pre", 64'(bus.o_Fifo_Level), 64'd2);
    rst_ = 1'b0;
    bus.i_Acc_DV = 1'b1;
    bus.i_Acc_Bytes = 64'h01_07_000011112222;
    @(negedge clk);
    rst_ = 1'b1;
    bus.i_Acc_DV = 1'b0;
    chk("rsti_valid", 64'(bus.o_Cmd_Valid),  64'd0);
    chk("rsti_level", 64'(bus.o_Fifo_Level), 64'd0);
    chk("rsti_data",  64'(bus.o_Cmd_Data),   64'd0);
    bus.i_Cmd_Ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("rsti_quiet_valid", 64'(bus.o_Cmd_Valid), 64'd0);
      chk("rsti_quiet_we",    64'(bus.o_Cfg_WE),    64'd0);
      @(negedge clk);
    end
    bus.i_Cmd_Ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_cmd_scheduler.md
SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

Interface
REQ-001 Parameter N_BYTES, default 8, packet width in bytes; the block SHALL support only N_BYTES=8.
REQ-002 Parameter FIFO_DEPTH, default 4, packet queue depth; the block SHALL accept powers of two from 2 to 16.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_  input  1  synchronous, active-low reset.
REQ-005 i_Acc_DV  input  1  one-cycle packet-valid strobe from the SPI byte accumulator.
REQ-006 i_Acc_Bytes  input  64  packet: [63:56] opcode, [55:48] addr, [47:0] payload.
REQ-007 o_Cfg_WE  output  1  config-register write strobe.
REQ-008 o_Cfg_Addr  output  4  config register index, equal to addr[3:0].
REQ-009 o_Cfg_Data  output  32  config write data, equal to payload[31:0].
REQ-010 o_Cmd_Valid  output  1  draw command valid to the render engine.
REQ-011 o_Cmd_Data  output  48  draw command payload.
REQ-012 i_Cmd_Ready  input  1  render engine accepts the command.
REQ-013 i_Engine_Busy  input  1  render engine has work in flight.
REQ-014 o_Fifo_Level  output  5  number of queued packets.
REQ-015 o_Overflow  output  1  sticky flag: a packet was dropped.
REQ-016 o_Err_Count  output  8  saturating count of illegal opcodes.

Function
REQ-017 Packet FIFO: a packet SHALL be pushed on each cycle with i_Acc_DV=1 when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-018 Overflow: i_Acc_DV=1 with the FIFO full and no pop SHALL drop the packet, leave the FIFO unchanged and set o_Overflow, which stays set until reset.
REQ-019 Level: a simultaneous push and pop SHALL leave o_Fifo_Level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 FSM states: IDLE, DECODE, ISSUE, WAIT_IDLE.
REQ-021 IDLE: when the FIFO is non-empty, the FSM SHALL pop the head into an internal command register and go to DECODE; otherwise it stays in IDLE.
REQ-022 DECODE, opcode 0x00 (NOP): the FSM SHALL return to IDLE with no output activity.
REQ-023 DECODE, opcode 0x01 (WRITE_REG): o_Cfg_WE SHALL be 1 for exactly the next cycle, with o_Cfg_Addr and o_Cfg_Data valid in that cycle; the FSM SHALL return to IDLE.
REQ-024 DECODE, opcode 0x02 (DRAW): the FSM SHALL go to ISSUE, and o_Cmd_Valid SHALL be 1 from the next cycle with o_Cmd_Data = payload.
REQ-025 DECODE, opcode 0x03 (SYNC): the FSM SHALL go to WAIT_IDLE.
REQ-026 DECODE, any other opcode: the FSM SHALL increment o_Err_Count, saturating at 0xFF, and return to IDLE.
REQ-027 ISSUE: o_Cmd_Valid and o_Cmd_Data SHALL hold stable until a cycle with i_Cmd_Ready=1; o_Cmd_Valid SHALL then drop on the next edge and the FSM SHALL return to IDLE.
REQ-028 WAIT_IDLE: the FSM SHALL remain in WAIT_IDLE while i_Engine_Busy=1 and return to IDLE on the first cycle it is 0, including the cycle immediately after entry.
REQ-029 Latency: with an empty FIFO and the FSM in IDLE, i_Acc_DV high in cycle 0 SHALL produce o_Cfg_WE or o_Cmd_Valid high in cycle 3.
REQ-030 Throughput: a packet SHALL be decoded at most once every 2 cycles (IDLE to DECODE); the FIFO SHALL keep accepting packets while the FSM is in ISSUE or WAIT_IDLE.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While rst_=0 at a clock edge, the block SHALL empty the FIFO, set the FSM to IDLE, and clear o_Cfg_WE, o_Cmd_Valid, o_Overflow, o_Err_Count and o_Fifo_Level to 0.
REQ-033 While rst_=0 at a clock edge, the block SHALL clear o_Cfg_Addr, o_Cfg_Data and o_Cmd_Data to 0.
REQ-034 A reset while in ISSUE or WAIT_IDLE SHALL abandon the command with no handshake, and o_Cmd_Valid SHALL be 0 after that edge.
REQ-035 i_Acc_DV SHALL be ignored in any cycle with rst_=0.

Verification
REQ-036 WRITE_REG 0x01_05_0000DEADBEEF into an idle block -> o_Cfg_WE=1 in cycle 3 only, o_Cfg_Addr=5, o_Cfg_Data=0xDEADBEEF.
REQ-037 DRAW 0x02_00_123456789ABC with i_Cmd_Ready held 0 for 5 cycles, then 1 -> o_Cmd_Valid high from cycle 3 through the handshake cycle, o_Cmd_Data=0x123456789ABC stable throughout.
REQ-038 SYNC with i_Engine_Busy=1 for 10 cycles, followed by a queued WRITE_REG -> o_Cfg_WE stays 0 until busy falls, then the write occurs.
REQ-039 6 DRAWs back-to-back, FIFO_DEPTH=4, i_Cmd_Ready=0 -> o_Fifo_Level reaches 4, o_Overflow=1, exactly 1 packet dropped (first DRAW already popped).
REQ-040 300 packets with opcode 0x7F -> o_Err_Count saturates at 0xFF; opcode 0x00 -> no output activity.
REQ-041 rst_=0 for 1 cycle while in ISSUE with 2 packets queued -> o_Cmd_Valid=0, o_Fifo_Level=0, FSM IDLE, and no command issued afterwards.
